// File: rtl/sample_delay_pkg.sv
// Shared types, Q1.15 feedback constants and the saturating adder for sample_delay_line.
package sample_delay_pkg;

  localparam int unsigned SAMPLE_W = 24;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int unsigned FB_FRAC = 15;
  localparam int unsigned FB_W    = 16;

  // Operands arrive sign-extended to 64 bits; the result clamps to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] s;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample store: one write port, one registered read port with enable.
module delay_ram #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_delay_line.sv
// Runtime-variable multi-channel sample delay line with valid/ready handshake.
// Define SAMPLE_DELAY_FEEDBACK_EN to write back in + delayed*fb_gain (saturated) instead of in.
module sample_delay_line
  import sample_delay_pkg::*;
#(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [$clog2(DEPTH)-1:0]  delay_len,
  input  logic [FB_W-1:0]           fb_gain,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = CHANNELS * WIDTH;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] frame_t;

  logic   adv, accept;
  addr_t  wp, fill;

  logic   s1_valid, s1_mask;
  frame_t s1_data;
  addr_t  s1_dlen, s1_wp;

  logic   s2_valid, s2_mask;
  frame_t s2_data;
  addr_t  s2_dlen, s2_wp;

  addr_t  rd_addr;
  frame_t rd_data, wr_data, delayed, out_next;
  logic   fwd;
  frame_t fwd_data;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // S1: capture the frame, its delay, its write slot and whether the slot it reads was ever written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp       <= '0;
      fill     <= '0;
      s1_valid <= 1'b0;
      s1_mask  <= 1'b0;
      s1_data  <= '0;
      s1_dlen  <= '0;
      s1_wp    <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= in_data;
        s1_dlen <= delay_len;
        s1_wp   <= wp;
        s1_mask <= (fill < delay_len);
        wp      <= wp + addr_t'(1);
        if (fill != addr_t'(DEPTH - 1)) fill <= fill + addr_t'(1);
      end
    end
  end

  assign rd_addr = s1_wp - s1_dlen;

  delay_ram #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (adv && s2_valid),
    .wr_addr (s2_wp),
    .wr_data (wr_data),
    .rd_en   (adv),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The RAM returns pre-write data on a same-edge address collision, so capture the write value instead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_mask  <= 1'b0;
      s2_data  <= '0;
      s2_dlen  <= '0;
      s2_wp    <= '0;
      fwd      <= 1'b0;
      fwd_data <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_mask  <= s1_mask;
      s2_data  <= s1_data;
      s2_dlen  <= s1_dlen;
      s2_wp    <= s1_wp;
      fwd      <= s2_valid && (rd_addr == s2_wp);
      fwd_data <= wr_data;
    end
  end

  assign delayed  = s2_mask ? '0 : (fwd ? fwd_data : rd_data);
  assign out_next = (s2_dlen == '0) ? s2_data : delayed;

`ifdef SAMPLE_DELAY_FEEDBACK_EN
  localparam int unsigned PW = WIDTH + FB_W;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_fb
    logic signed [WIDTH-1:0] in_s, dly_s;
    logic signed [PW-1:0]    prod, fb;

    assign in_s  = s2_data[c*WIDTH +: WIDTH];
    assign dly_s = delayed[c*WIDTH +: WIDTH];
    assign prod  = PW'(dly_s) * PW'($signed(fb_gain));
    assign fb    = (s2_dlen == '0) ? '0 : (prod >>> FB_FRAC);
    assign wr_data[c*WIDTH +: WIDTH] = WIDTH'(sat_add(64'(in_s), 64'(fb), WIDTH));
  end
`else
  logic unused_fb_gain;
  assign unused_fb_gain = ^fb_gain;
  assign wr_data        = s2_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) out_data <= out_next;
    end
  end

endmodule

// File: tb/tb_sample_delay_line.sv
// Directed bench for sample_delay_line (DEPTH=16, WIDTH=24, CHANNELS=2).
module tb_sample_delay_line;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [3:0]  delay_len;
  logic [15:0] fb_gain;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [47:0] vin[$];
  logic [47:0] vexp[$];

  always #5 clk = ~clk;

  sample_delay_line #(
    .WIDTH    (24),
    .DEPTH    (16),
    .CHANNELS (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .delay_len (delay_len),
    .fb_gain   (fb_gain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [47:0] mk(input logic [23:0] v);
    return {~v, v};
  endfunction

  function automatic logic [47:0] mk2(input logic [23:0] v);
    return {v, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Feeds vin back-to-back and expects vexp[i] two edges after frame i is accepted.
  task automatic run_seq(input string tag, input int dl);
    int n;
    n = vin.size();
    delay_len = 4'(dl);
    for (int i = 0; i < n + 2; i++) begin
      in_valid = (i < n);
      in_data  = (i < n) ? vin[i] : 48'h0;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, out_valid, (i >= 2));
      if (i >= 2) chk({tag, "_data"}, out_data, vexp[i-2]);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, j, acc;
    logic prev_stall;
    logic [47:0] exp_o;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    delay_len = '0;
    fb_gain   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;

    // Basic delay of 3 frames on a ramp
    vin  = '{mk(24'd1), mk(24'd2), mk(24'd3), mk(24'd4), mk(24'd5), mk(24'd6)};
    vexp = '{48'h0, 48'h0, 48'h0, mk(24'd1), mk(24'd2), mk(24'd3)};
    run_seq("basic", 3);

    // Bypass with full-scale extremes
    vin  = '{mk(24'h7FFFFF), mk(24'h800000)};
    vexp = '{48'h8000007FFFFF, 48'h7FFFFF800000};
    run_seq("bypass", 0);

    // Back-pressure and pointer wrap
    do_reset();
    delay_len  = 4'd15;
    k          = 0;
    j          = 0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 400 && j < 40; cyc++) begin
      out_ready = ((cyc / 3) % 2) == 0;
      in_valid  = (k < 40);
      in_data   = mk(24'(100 + k));
      #1;
      chk("bp_in_ready", in_ready, (!out_valid || out_ready));
      if (prev_stall) chk("bp_hold_valid", out_valid, 1);
      if (out_valid) begin
        exp_o = (j < 15) ? 48'h0 : mk(24'(100 + j - 15));
        chk("bp_data", out_data, exp_o);
        if (out_ready) j++;
      end
      acc        = int'(in_valid && in_ready);
      prev_stall = out_valid && !out_ready;
      @(posedge clk);
      #1;
      if (acc != 0) k++;
    end
    chk("bp_out_count", j, 40);
    chk("bp_in_count", k, 40);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset with frames in flight, then restart over stale RAM
    delay_len = 4'd3;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = mk(24'(24'h55 + i));
      @(posedge clk);
      #1;
    end
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    vin  = '{mk(24'd200), mk(24'd201), mk(24'd202), mk(24'd203), mk(24'd204), mk(24'd205)};
    vexp = '{48'h0, 48'h0, 48'h0, mk(24'd200), mk(24'd201), mk(24'd202)};
    run_seq("restart", 3);

`ifdef SAMPLE_DELAY_FEEDBACK_EN
    // Feedback through the forwarding path at delay 1, gain 0.5
    do_reset();
    fb_gain = 16'h4000;
    vin  = '{mk2(24'h100000), 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
    vexp = '{48'h0, mk2(24'h100000), mk2(24'h080000), mk2(24'h040000),
             mk2(24'h020000), mk2(24'h010000)};
    run_seq("fwd", 1);

    // Saturating feedback, gain just under 1.0
    do_reset();
    fb_gain = 16'h7FFF;
    vin  = '{mk2(24'h600000), mk2(24'h600000), mk2(24'h600000),
             mk2(24'h600000), mk2(24'h600000), mk2(24'h600000)};
    vexp = '{48'h0, 48'h0, mk2(24'h600000), mk2(24'h600000),
             mk2(24'h7FFFFF), mk2(24'h7FFFFF)};
    run_seq("sat", 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
